// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register.
// Contents:
//   - ALU operation class encodings.
//   - MIPS funct field constants.
//   - Bit positions inside the 6-bit control bundle.
//   - The control value written into a bubble slot.
package id_ex_reg_pkg;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpRtype = 2'b10
  } alu_op_e;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctXor = 6'b100110;
  localparam logic [5:0] FunctNor = 6'b100111;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // Control bundle layout: {RegDst, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite}
  localparam int unsigned CtrlRegDst   = 5;
  localparam int unsigned CtrlAluSrc   = 4;
  localparam int unsigned CtrlMemRead  = 3;
  localparam int unsigned CtrlMemWrite = 2;
  localparam int unsigned CtrlMemtoReg = 1;
  localparam int unsigned CtrlRegWrite = 0;

  // All-zero control: no memory access and no register write downstream.
  localparam logic [5:0] CtrlBubble = 6'b000000;

  localparam logic [5:0] FunctBubble = 6'b000000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear, wins over inc
//   inc   - count one event this edge
//   count - current value, sticks at all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for a classic 5-stage MIPS pipeline.
// Per-edge priority: reset > flush > stall > load.
//   - flush turns the slot into a bubble (control zeroed, data/specifiers held)
//   - stall holds every field
//   - load with id_valid=0 captures data but writes a bubble control bundle
// All outputs come straight from flops.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   stall, flush         - hazard controls
//   id_*                 - decoded instruction fields from ID
//   ex_*                 - registered copies for EX
//   bubble_cnt/stall_cnt - 16-bit saturating statistics (IDEX_PERF_CNT_EN only)
// Optional feature macro: IDEX_PERF_CNT_EN adds the two performance counters.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [1:0]        id_ALUOp,
  input  logic [5:0]        id_FuncCode,
  input  logic [5:0]        id_ctrl,
  input  logic [DATA_W-1:0] id_PC4,
  input  logic [DATA_W-1:0] id_ReadData1,
  input  logic [DATA_W-1:0] id_ReadData2,
  input  logic [DATA_W-1:0] id_SignExt,
  input  logic [REG_W-1:0]  id_Rs,
  input  logic [REG_W-1:0]  id_Rt,
  input  logic [REG_W-1:0]  id_Rd,
  output logic              ex_valid,
  output logic [1:0]        ex_ALUOp,
  output logic [5:0]        ex_FuncCode,
  output logic [5:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_PC4,
  output logic [DATA_W-1:0] ex_ReadData1,
  output logic [DATA_W-1:0] ex_ReadData2,
  output logic [DATA_W-1:0] ex_SignExt,
  output logic [REG_W-1:0]  ex_Rs,
  output logic [REG_W-1:0]  ex_Rt,
  output logic [REG_W-1:0]  ex_Rd
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  logic              valid_q;
  logic [1:0]        alu_op_q;
  logic [5:0]        funct_q;
  logic [5:0]        ctrl_q;
  logic [DATA_W-1:0] pc4_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] sext_q;
  logic [REG_W-1:0]  rs_q;
  logic [REG_W-1:0]  rt_q;
  logic [REG_W-1:0]  rd_q;

  logic load;
  assign load = !flush && !stall;

  // Control-class fields: these are the ones a bubble must neutralise.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      alu_op_q <= AluOpAdd;
      funct_q  <= FunctBubble;
      ctrl_q   <= CtrlBubble;
    end else if (flush) begin
      valid_q  <= 1'b0;
      alu_op_q <= AluOpAdd;
      funct_q  <= FunctBubble;
      ctrl_q   <= CtrlBubble;
    end else if (load) begin
      valid_q  <= id_valid;
      alu_op_q <= id_valid ? id_ALUOp : AluOpAdd;
      funct_q  <= id_FuncCode;
      ctrl_q   <= id_valid ? id_ctrl : CtrlBubble;
    end
  end

  // Data and specifier fields: held on flush so forwarding/debug still sees them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc4_q  <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      sext_q <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
    end else if (load) begin
      pc4_q  <= id_PC4;
      rd1_q  <= id_ReadData1;
      rd2_q  <= id_ReadData2;
      sext_q <= id_SignExt;
      rs_q   <= id_Rs;
      rt_q   <= id_Rt;
      rd_q   <= id_Rd;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_ALUOp     = alu_op_q;
  assign ex_FuncCode  = funct_q;
  assign ex_ctrl      = ctrl_q;
  assign ex_PC4       = pc4_q;
  assign ex_ReadData1 = rd1_q;
  assign ex_ReadData2 = rd2_q;
  assign ex_SignExt   = sext_q;
  assign ex_Rs        = rs_q;
  assign ex_Rt        = rt_q;
  assign ex_Rd        = rd_q;

`ifdef IDEX_PERF_CNT_EN
  logic bubble_wr;
  logic stall_ev;

  // A bubble is written by any flush, or by a load of an invalid ID slot.
  assign bubble_wr = flush || (load && !id_valid);
  assign stall_ev  = stall && !flush;

  sat_counter #(
    .WIDTH (16)
  ) u_bubble_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (bubble_wr),
    .count (bubble_cnt)
  );

  sat_counter #(
    .WIDTH (16)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (stall_ev),
    .count (stall_cnt)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
module tb_id_ex_reg;
  import id_ex_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [1:0]  id_ALUOp;
  logic [5:0]  id_FuncCode, id_ctrl;
  logic [31:0] id_PC4, id_ReadData1, id_ReadData2, id_SignExt;
  logic [4:0]  id_Rs, id_Rt, id_Rd;
  logic        ex_valid;
  logic [1:0]  ex_ALUOp;
  logic [5:0]  ex_FuncCode, ex_ctrl;
  logic [31:0] ex_PC4, ex_ReadData1, ex_ReadData2, ex_SignExt;
  logic [4:0]  ex_Rs, ex_Rt, ex_Rd;
`ifdef IDEX_PERF_CNT_EN
  logic [15:0] bubble_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(
    .DATA_W (32),
    .REG_W  (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .id_valid     (id_valid),
    .id_ALUOp     (id_ALUOp),
    .id_FuncCode  (id_FuncCode),
    .id_ctrl      (id_ctrl),
    .id_PC4       (id_PC4),
    .id_ReadData1 (id_ReadData1),
    .id_ReadData2 (id_ReadData2),
    .id_SignExt   (id_SignExt),
    .id_Rs        (id_Rs),
    .id_Rt        (id_Rt),
    .id_Rd        (id_Rd),
    .ex_valid     (ex_valid),
    .ex_ALUOp     (ex_ALUOp),
    .ex_FuncCode  (ex_FuncCode),
    .ex_ctrl      (ex_ctrl),
    .ex_PC4       (ex_PC4),
    .ex_ReadData1 (ex_ReadData1),
    .ex_ReadData2 (ex_ReadData2),
    .ex_SignExt   (ex_SignExt),
    .ex_Rs        (ex_Rs),
    .ex_Rt        (ex_Rt),
    .ex_Rd        (ex_Rd)
`ifdef IDEX_PERF_CNT_EN
    ,
    .bubble_cnt   (bubble_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [1:0] op,
                           input logic [5:0] fn, input logic [5:0] ct, input logic [31:0] pc4,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    check({tag, ".valid"}, 32'(ex_valid), 32'(v));
    check({tag, ".ALUOp"}, 32'(ex_ALUOp), 32'(op));
    check({tag, ".FuncCode"}, 32'(ex_FuncCode), 32'(fn));
    check({tag, ".ctrl"}, 32'(ex_ctrl), 32'(ct));
    check({tag, ".PC4"}, ex_PC4, pc4);
    check({tag, ".ReadData1"}, ex_ReadData1, r1);
    check({tag, ".ReadData2"}, ex_ReadData2, r2);
    check({tag, ".SignExt"}, ex_SignExt, se);
    check({tag, ".Rs"}, 32'(ex_Rs), 32'(rs));
    check({tag, ".Rt"}, 32'(ex_Rt), 32'(rt));
    check({tag, ".Rd"}, 32'(ex_Rd), 32'(rd));
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [5:0] ct, input logic [31:0] pc4, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] se, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_ALUOp = op; id_FuncCode = fn; id_ctrl = ct; id_PC4 = pc4;
    id_ReadData1 = r1; id_ReadData2 = r2; id_SignExt = se;
    id_Rs = rs; id_Rt = rt; id_Rd = rd;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset wins over concurrent stall and flush.
    reset = 1'b1; stall = 1'b1; flush = 1'b1;
    drive(1'b1, 2'b10, 6'b100000, 6'b111111, 32'hDEAD, 32'h11, 32'h22, 32'h33, 5'd7, 5'd8, 5'd9);
    step();
    step();
    check_all("reset", 1'b0, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    // Plain load of an R-type sub.
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 2'b10, 6'b100010, 6'b100001, 32'h104, 32'h5, 32'h3, 32'h20, 5'd1, 5'd2, 5'd3);
    step();
    check_all("load", 1'b1, 2'b10, 6'b100010, 6'b100001, 32'h104, 32'h5, 32'h3, 32'h20,
              5'd1, 5'd2, 5'd3);

    // Stall three cycles while ID changes underneath.
    stall = 1'b1;
    drive(1'b1, 2'b00, 6'b100100, 6'b011011, 32'h108, 32'hFFFF, 32'h44, 32'h55, 5'd4, 5'd5, 5'd6);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("stall", 1'b1, 2'b10, 6'b100010, 6'b100001, 32'h104, 32'h5, 32'h3, 32'h20,
                5'd1, 5'd2, 5'd3);
    end
    stall = 1'b0;
    step();
    check_all("release", 1'b1, 2'b00, 6'b100100, 6'b011011, 32'h108, 32'hFFFF, 32'h44, 32'h55,
              5'd4, 5'd5, 5'd6);

    // Invalid ID slot loads as a bubble but data still flows.
    drive(1'b0, 2'b01, 6'b100101, 6'b111111, 32'h10C, 32'h7, 32'h8, 32'h9, 5'd10, 5'd11, 5'd12);
    step();
    check_all("invalid", 1'b0, 2'b00, 6'b100101, 6'b000000, 32'h10C, 32'h7, 32'h8, 32'h9,
              5'd10, 5'd11, 5'd12);

    // sw: ALUSrc + MemWrite.
    drive(1'b1, 2'b00, 6'b000000, 6'b010100, 32'h110, 32'h100, 32'hAA, 32'h4, 5'd13, 5'd14, 5'd0);
    step();
    check_all("sw", 1'b1, 2'b00, 6'b000000, 6'b010100, 32'h110, 32'h100, 32'hAA, 32'h4,
              5'd13, 5'd14, 5'd0);

    // Stall and flush together on the held sw: control cleared, data kept.
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 2'b10, 6'b101010, 6'b100001, 32'h114, 32'h1, 32'hBB, 32'h2, 5'd15, 5'd16, 5'd17);
    step();
    check_all("stall_flush", 1'b0, 2'b00, 6'b000000, 6'b000000, 32'h110, 32'h100, 32'hAA, 32'h4,
              5'd13, 5'd14, 5'd0);

    // Flush alone also keeps data.
    stall = 1'b0;
    drive(1'b1, 2'b10, 6'b100111, 6'b100001, 32'h118, 32'h3, 32'hCC, 32'h6, 5'd18, 5'd19, 5'd20);
    step();
    check_all("flush", 1'b0, 2'b00, 6'b000000, 6'b000000, 32'h110, 32'h100, 32'hAA, 32'h4,
              5'd13, 5'd14, 5'd0);

    // Hold an R-type under stall, then reset discards it.
    flush = 1'b0;
    drive(1'b1, 2'b10, 6'b100110, 6'b100001, 32'h11C, 32'h12, 32'h34, 32'h56, 5'd21, 5'd22, 5'd23);
    step();
    stall = 1'b1;
    drive(1'b1, 2'b01, 6'b100000, 6'b001011, 32'h120, 32'h99, 32'h98, 32'h97, 5'd24, 5'd25, 5'd26);
    step();
    check_all("held_rtype", 1'b1, 2'b10, 6'b100110, 6'b100001, 32'h11C, 32'h12, 32'h34, 32'h56,
              5'd21, 5'd22, 5'd23);
    reset = 1'b1;
    step();
    check_all("reset_mid_stall", 1'b0, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0,
              5'd0, 5'd0, 5'd0);
    reset = 1'b0; stall = 1'b0;
    step();
    check_all("post_reset_load", 1'b1, 2'b01, 6'b100000, 6'b001011, 32'h120, 32'h99, 32'h98,
              32'h97, 5'd24, 5'd25, 5'd26);

`ifdef IDEX_PERF_CNT_EN
    reset = 1'b1;
    step();
    check("bubble_cnt_reset", 32'(bubble_cnt), 32'd0);
    check("stall_cnt_reset", 32'(stall_cnt), 32'd0);
    reset = 1'b0;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    id_valid = 1'b0;
    step();
    id_valid = 1'b1;
    stall = 1'b1;
    repeat (4) step();
    check("bubble_cnt", 32'(bubble_cnt), 32'd3);
    check("stall_cnt", 32'(stall_cnt), 32'd4);
    repeat (65540) @(posedge clk);
    #1;
    check("stall_cnt_sat", 32'(stall_cnt), 32'h0000FFFF);
    check("bubble_cnt_steady", 32'(bubble_cnt), 32'd3);
    stall = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
